// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, instruction register and return-address stack.
// Define PERF_CNT_EN to add saturating retired/taken instruction counters.
module fetch_unit #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned STACK_DEPTH = 8,
   localparam int unsigned SP_W       = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               bra,
   input  logic               jmp,
   input  logic               psh,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  jmp_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic [SP_W-1:0]    sp,
   output logic               fault
`ifdef PERF_CNT_EN
   ,
   output logic [15:0]        retired_cnt,
   output logic [15:0]        taken_cnt
`endif
);

   localparam int unsigned IDX_W = SP_W - 1;

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               fault_q, fault_d;
   logic               ign_ack_q;
   logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
   logic               push_en;
   logic               halt_now;
   logic [SP_W-1:0]    sp_dec;
   logic [ADDR_W-1:0]  pc_inc;

   assign sp_dec = sp_q - SP_W'(1);
   assign pc_inc = pc_q + ADDR_W'(1);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      sp_d     = sp_q;
      instr_d  = instr_q;
      fault_d  = fault_q;
      push_en  = 1'b0;
      halt_now = 1'b0;
      unique case (state_q)
         StFetch: begin
            // The first ack after reset may belong to a read issued before reset.
            if (imem_ack && !ign_ack_q) begin
               instr_d = imem_rdata;
               state_d = StExec;
            end
         end
         StExec: begin
            if (!stall) begin
               state_d = StFetch;
               if (bra && jmp && psh && pop) begin
                  halt_now = 1'b1;
               end else if (bra && jmp && pop) begin
                  if (sp_q == '0) begin
                     halt_now = 1'b1;
                  end else begin
                     pc_d = stack_q[sp_dec[IDX_W-1:0]];
                     sp_d = sp_dec;
                  end
               end else if (bra && jmp && psh) begin
                  if (sp_q == SP_W'(STACK_DEPTH)) begin
                     halt_now = 1'b1;
                  end else begin
                     push_en = 1'b1;
                     sp_d    = sp_q + SP_W'(1);
                     pc_d    = jmp_addr;
                  end
               end else if (bra) begin
                  pc_d = jmp_addr;
               end else begin
                  pc_d = pc_inc;
               end
               if (halt_now) begin
                  fault_d = 1'b1;
                  state_d = StHalt;
               end
            end
         end
         StHalt: begin
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         pc_q      <= '0;
         sp_q      <= '0;
         instr_q   <= '0;
         fault_q   <= 1'b0;
         ign_ack_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sp_q      <= sp_d;
         instr_q   <= instr_d;
         fault_q   <= fault_d;
         ign_ack_q <= 1'b0;
      end
   end

   // Stack storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
      end
   end

   assign imem_req    = (state_q == StFetch) && !reset;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == StExec) && !reset;
   assign pc          = pc_q;
   assign sp          = sp_q;
   assign fault       = fault_q;

`ifdef PERF_CNT_EN
   logic        retire;
   logic [15:0] retired_q, retired_d;
   logic [15:0] taken_q, taken_d;

   always_comb begin
      retire    = (state_q == StExec) && !stall && !halt_now;
      retired_d = retired_q;
      taken_d   = taken_q;
      if (retire && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
      if (retire && bra && (taken_q != 16'hFFFF)) taken_d = taken_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         retired_q <= retired_d;
         taken_q   <= taken_d;
      end
   end

   assign retired_cnt = retired_q;
   assign taken_cnt   = taken_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction-level reference model with a queue
// as return stack, plus a latency-programmable memory responder.
module tb_fetch_unit;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        stall;
   logic [15:0] instr;
   logic        instr_valid;
   logic        bra, jmp, psh, pop;
   logic [9:0]  jmp_addr;
   logic [9:0]  pc;
   logic [3:0]  sp;
   logic        fault;
`ifdef PERF_CNT_EN
   logic [15:0] retired_cnt, taken_cnt;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(10), .INSTR_W(16), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .instr(instr),
      .instr_valid(instr_valid), .bra(bra), .jmp(jmp), .psh(psh), .pop(pop),
      .jmp_addr(jmp_addr), .pc(pc), .sp(sp), .fault(fault)
`ifdef PERF_CNT_EN
      , .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
`endif
   );

   logic [15:0] mem [1024];
   int          lat, wcnt, cyc, n_checks, n_fail, last_exec_cyc, fetch_cycles;
   logic [9:0]  mpc;
   logic [9:0]  mstack [$];
   bit          mhalt;

   // One clock; memory acks a pending request after lat wait cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (imem_req === 1'b1) begin
         if (wcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            wcnt       = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            wcnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end
   endtask

   task automatic model_reset();
      mpc   = '0;
      mhalt = 1'b0;
      mstack.delete();
   endtask

   task automatic model_apply(input logic b, j, ps, po, input logic [9:0] ta);
      logic [9:0] ret;
      if (mhalt) return;
      ret = mpc + 10'd1;
      if (b && j && ps && po) mhalt = 1'b1;
      else if (b && j && po) begin
         if (mstack.size() == 0) mhalt = 1'b1;
         else mpc = mstack.pop_back();
      end else if (b && j && ps) begin
         if (mstack.size() == DEPTH) mhalt = 1'b1;
         else begin
            mstack.push_back(ret);
            mpc = ta;
         end
      end else if (b) mpc = ta;
      else mpc = ret;
   endtask

   // late_ack presents a stale ack in the first cycle after reset.
   task automatic do_reset(input bit late_ack);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      if (late_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 16'hDEAD;
      end else begin
         imem_ack = 1'b0;
      end
      wcnt = 0;
      model_reset();
   endtask

   // Fetch one instruction, hold it nstall cycles with noise on the controls, then issue ops.
   task automatic step_instr(input logic b, j, ps, po, input logic [9:0] ta, input int nstall);
      int          guard;
      logic [15:0] held;
      guard        = 0;
      fetch_cycles = 0;
      while (instr_valid !== 1'b1 && guard < 40) begin
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== mpc) begin
            n_fail++;
            $display("FAIL fetch_addr: req=%b addr=%h, required req=1 addr=%h",
                     imem_req, imem_addr, mpc);
         end
         tick();
         guard++;
         fetch_cycles++;
      end
      n_checks++;
      if (guard >= 40) begin
         n_fail++;
         $display("FAIL exec_timeout: instr_valid=%b after 40 cycles, required 1 (pc %h)",
                  instr_valid, mpc);
         return;
      end
      last_exec_cyc = cyc;
      n_checks++;
      if (pc !== mpc || instr !== mem[mpc] || sp !== 4'(mstack.size()) || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL exec_entry: pc=%h instr=%h sp=%0d fault=%b, required %h %h %0d 0",
                  pc, instr, sp, fault, mpc, mem[mpc], mstack.size());
      end
      held = instr;
      for (int s = 0; s < nstall; s++) begin
         stall    = 1'b1;
         bra      = 1'($urandom);
         jmp      = 1'($urandom);
         psh      = 1'($urandom);
         pop      = 1'($urandom);
         jmp_addr = 10'($urandom);
         tick();
         n_checks++;
         if (instr_valid !== 1'b1 || pc !== mpc || instr !== held || sp !== 4'(mstack.size())
             || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b pc=%h instr=%h sp=%0d fault=%b, required 1 %h %h %0d 0",
                     instr_valid, pc, instr, sp, fault, mpc, held, mstack.size());
         end
      end
      stall    = 1'b0;
      bra      = b;
      jmp      = j;
      psh      = ps;
      pop      = po;
      jmp_addr = ta;
      tick();
      model_apply(b, j, ps, po, ta);
      {bra, jmp, psh, pop} = 4'b0000;
      n_checks++;
      if (mhalt) begin
         if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== mpc) begin
            n_fail++;
            $display("FAIL halt_entry: fault=%b req=%b valid=%b pc=%h, required 1 0 0 %h",
                     fault, imem_req, instr_valid, pc, mpc);
         end
      end else if (fault !== 1'b0 || instr_valid !== 1'b0 || pc !== mpc
                   || sp !== 4'(mstack.size())) begin
         n_fail++;
         $display("FAIL next_pc: fault=%b valid=%b pc=%h sp=%0d, required 0 0 %h %0d",
                  fault, instr_valid, pc, sp, mpc, mstack.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b valid=%b, required 0 0", imem_req, instr_valid);
      end
      do_reset(1'b0);
      n_checks++;
      if (pc !== 10'd0 || sp !== 4'd0 || instr !== 16'd0 || instr_valid !== 1'b0
          || fault !== 1'b0 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: pc=%h sp=%0d instr=%h valid=%b fault=%b req=%b, required 0 0 0 0 0 1",
                  pc, sp, instr, instr_valid, fault, imem_req);
      end
   endtask

   task automatic test_sequential();
      int prev;
      lat = 0;
      do_reset(1'b0);
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      for (int i = 1; i < 4; i++) begin
         prev = last_exec_cyc;
         step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
         n_checks++;
         if (last_exec_cyc - prev != 2) begin
            n_fail++;
            $display("FAIL seq_rate: %0d cycles per instruction, required 2", last_exec_cyc - prev);
         end
      end
   endtask

   task automatic test_branch();
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      step_instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h040, 0);
      n_checks++;
      if (imem_addr !== 10'h040 || sp !== 4'd0) begin
         n_fail++;
         $display("FAIL branch_target: addr=%h sp=%0d, required 040 0", imem_addr, sp);
      end
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h155, 0);
   endtask

   task automatic test_call_ret();
      logic [9:0] frozen;
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      step_instr(1'b1, 1'b1, 1'b1, 1'b0, 10'h100, 0);
      step_instr(1'b1, 1'b1, 1'b0, 1'b1, 10'h2F0, 0);
      n_checks++;
      if (pc !== 10'h004 || sp !== 4'd0) begin
         n_fail++;
         $display("FAIL call_return: pc=%h sp=%0d, required 004 0", pc, sp);
      end
      for (int i = 0; i < DEPTH; i++) step_instr(1'b1, 1'b1, 1'b1, 1'b0, 10'($urandom), 0);
      step_instr(1'b1, 1'b1, 1'b1, 1'b0, 10'h321, 0);
      frozen = mpc;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (imem_req !== 1'b0 || fault !== 1'b1 || pc !== frozen || sp !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_halt: req=%b fault=%b pc=%h sp=%0d, required 0 1 %h 8",
                     imem_req, fault, pc, sp, frozen);
         end
      end
   endtask

   task automatic test_underflow();
      do_reset(1'b0);
      for (int i = 0; i < 2; i++) step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      step_instr(1'b1, 1'b1, 1'b0, 1'b1, 10'h077, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (fault !== 1'b1 || pc !== 10'h002 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_halt: fault=%b pc=%h valid=%b, required 1 002 0",
                     fault, pc, instr_valid);
         end
      end
      do_reset(1'b0);
      n_checks++;
      if (pc !== 10'd0 || sp !== 4'd0 || fault !== 1'b0 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_reset: pc=%h sp=%0d fault=%b req=%b, required 0 0 0 1",
                  pc, sp, fault, imem_req);
      end
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
   endtask

   task automatic test_stall();
      do_reset(1'b0);
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 2);
      lat = 4;
      step_instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h2A0, 3);
      n_checks++;
      if (pc !== 10'h2A0) begin
         n_fail++;
         $display("FAIL stall_branch: pc=%h, required 2a0", pc);
      end
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      n_checks++;
      if (fetch_cycles != 5) begin
         n_fail++;
         $display("FAIL slow_fetch: %0d fetch cycles, required 5", fetch_cycles);
      end
      lat = 0;
   endtask

   task automatic test_wrap_and_late_ack();
      do_reset(1'b0);
      step_instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 0);
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
      n_checks++;
      if (pc !== 10'h000) begin
         n_fail++;
         $display("FAIL pc_wrap: pc=%h, required 000", pc);
      end
      lat = 6;
      step_instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h1C3, 0);
      tick();
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h1C3) begin
         n_fail++;
         $display("FAIL fetch_wait: req=%b addr=%h, required 1 1c3", imem_req, imem_addr);
      end
      lat = 0;
      do_reset(1'b1);
      step_instr(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 0);
   endtask

   task automatic test_random();
      int         r, ns;
      logic       b, j, ps, po;
      logic [9:0] ta;
      do_reset(1'b0);
      for (int i = 0; i < 150; i++) begin
         if (mhalt) do_reset(1'b0);
         lat = $urandom_range(0, 3);
         r   = $urandom_range(0, 15);
         ta  = 10'($urandom);
         ns  = $urandom_range(0, 2);
         if (r < 6) begin
            b = 1'b0; j = 1'($urandom); ps = 1'($urandom); po = 1'($urandom);
         end else if (r < 9) begin
            b = 1'b1; j = 1'b0; ps = 1'($urandom); po = 1'($urandom);
         end else if (r < 12) begin
            b = 1'b1; j = 1'b1; ps = 1'b1; po = 1'b0;
         end else if (r < 15) begin
            b = 1'b1; j = 1'b1; ps = 1'b0; po = 1'b1;
         end else begin
            b = 1'b1; j = 1'b1; ps = 1'b1; po = 1'b1;
         end
         step_instr(b, j, ps, po, ta, ns);
      end
      lat = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      wcnt     = 0;
      lat      = 0;
      reset    = 1'b1;
      stall    = 1'b0;
      {bra, jmp, psh, pop} = 4'b0000;
      jmp_addr   = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1234;
      model_reset();
      tick();
      test_reset();
      test_sequential();
      test_branch();
      test_call_ret();
      test_underflow();
      test_stall();
      test_wrap_and_late_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
